// File: rtl/logic_op_pkg.sv
// ============================================================================
// logic_op_pkg : op codes and shared constants for the logic-op arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4
  } logic_op_e;

  localparam int STAT_W = 16;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_arbiter_logic_unit.sv
// ============================================================================
// logic_unit : combinational W-bit bitwise logic unit with illegal-op flag
// Rev 1.0
// ============================================================================
`default_nettype none

import logic_op_pkg::*;

module logic_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = '0;
    err = !is_legal_op(op);
    case (logic_op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// ============================================================================
// logic_op_arbiter : round-robin sharing of one logic unit among N requesters
// Optional grant counters: LOGIC_OP_ARBITER_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

import logic_op_pkg::*;

module logic_op_arbiter #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [3*N-1:0]         req_op,
  input  logic [W*N-1:0]         req_a,
  input  logic [W*N-1:0]         req_b,
`ifdef LOGIC_OP_ARBITER_STATS_EN
  input  logic [$clog2(N)-1:0]   stat_sel,
  output logic [STAT_W-1:0]      stat_cnt,
`endif
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_y,
  output logic [$clog2(N)-1:0]   res_id,
  output logic                   res_err
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] last;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] idx;
  logic           found;
  logic           can_accept;
  logic           hs;
  logic [2:0]     op_sel;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W-1:0]   y_w;
  logic           err_w;

  assign can_accept = !res_valid || res_ready;

  // Scan starts one past the last winner; only valids feed the grant path.
  always_comb begin
    int pos;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last) + k;
      if (pos >= N) pos = pos - N;
      idx = pos[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign hs        = found && can_accept;
  assign req_ready = hs ? (N'(1) << gidx) : '0;

  assign op_sel = req_op[3*gidx +: 3];
  assign a_sel  = req_a[W*gidx +: W];
  assign b_sel  = req_b[W*gidx +: W];

  logic_unit #(.W(W)) u_logic_unit (
    .a   (a_sel),
    .b   (b_sel),
    .op  (op_sel),
    .y   (y_w),
    .err (err_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
      last      <= IDW'(N - 1);
    end else if (hs) begin
      res_valid <= 1'b1;
      res_y     <= y_w;
      res_id    <= gidx;
      res_err   <= err_w;
      last      <= gidx;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef LOGIC_OP_ARBITER_STATS_EN
  logic [STAT_W-1:0] cnt [N];

  for (genvar i = 0; i < N; i++) begin : g_stat
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt[i] <= '0;
      end else if (hs && (gidx == IDW'(i)) && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + STAT_W'(1);
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < N) ? cnt[stat_sel] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
// ============================================================================
// tb_logic_op_arbiter : directed self-checking bench for logic_op_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_logic_op_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_y;
  logic [1:0]     res_id;
  logic           res_err;
`ifdef LOGIC_OP_ARBITER_STATS_EN
  logic [1:0]     stat_sel;
  logic [15:0]    stat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic_op_arbiter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef LOGIC_OP_ARBITER_STATS_EN
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    req_valid[i]    = v;
    req_op[3*i +: 3] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int rr1 [6] = '{0, 1, 2, 3, 0, 1};
  int rr2 [4] = '{2, 3, 0, 2};
  logic [3:0] ops_y [5] = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1};

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
`ifdef LOGIC_OP_ARBITER_STATS_EN
    stat_sel  = '0;
`endif
    tick();
    tick();
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_y",     32'(res_y),     32'd0);
    check("rst_id",    32'(res_id),    32'd0);
    check("rst_err",   32'(res_err),   32'd0);
    reset_n = 1'b1;

    // Single XOR from requester 2
    set_req(2, 1'b1, 3'd2, 4'b1100, 4'b1010);
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    set_req(2, 1'b0, 3'd0, 4'h0, 4'h0);
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_y",     32'(res_y),     32'b0110);
    check("single_id",    32'(res_id),    32'd2);
    check("single_err",   32'(res_err),   32'd0);

    // All ops back-to-back from requester 0
    for (int j = 0; j < 5; j++) begin
      set_req(0, 1'b1, 3'(j), 4'hC, 4'hA);
      #1;
      check("ops_ready", 32'(req_ready), 32'b0001);
      tick();
      check("ops_valid", 32'(res_valid), 32'd1);
      check("ops_y",     32'(res_y),     32'(ops_y[j]));
    end
    set_req(0, 1'b0, 3'd0, 4'h0, 4'h0);

    // Round robin with all four requesting
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd1, 4'(i), 4'h8);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << rr1[k]));
      tick();
      check("rr_id", 32'(res_id), 32'(rr1[k]));
    end
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_drop_ready", 32'(req_ready), 32'(1 << rr2[k]));
      tick();
      check("rr_drop_id", 32'(res_id), 32'(rr2[k]));
    end

    // Backpressure: result from requester 2 held
    res_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_y",     32'(res_y),     32'hA);
      check("bp_id",    32'(res_id),    32'd2);
      check("bp_err",   32'(res_err),   32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    check("bp_new_id", 32'(res_id), 32'd3);
    check("bp_new_y",  32'(res_y),  32'hB);

    // Illegal op from requester 1 (pointer currently at 3)
    req_valid = '0;
    set_req(1, 1'b1, 3'd6, 4'hF, 4'hF);
    #1;
    check("ill_ready", 32'(req_ready), 32'b0010);
    tick();
    check("ill_y",   32'(res_y),   32'd0);
    check("ill_err", 32'(res_err), 32'd1);
    check("ill_id",  32'(res_id),  32'd1);
    set_req(1, 1'b1, 3'd0, 4'hF, 4'hF);
    set_req(2, 1'b1, 3'd0, 4'hF, 4'hF);
    #1;
    check("ill_ptr_adv", 32'(req_ready), 32'b0100);
    tick();
    check("ill_next_err", 32'(res_err), 32'd0);

    // Reset during a stall
    res_ready = 1'b0;
    tick();
    check("mid_pre_valid", 32'(res_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(res_valid), 32'd0);
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, 4'h1, 4'h1);
    #1;
    check("mid_first_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;

`ifdef LOGIC_OP_ARBITER_STATS_EN
    do_reset();
    set_req(1, 1'b1, 3'd0, 4'h3, 4'h3);
    tick();
    tick();
    tick();
    req_valid = '0;
    stat_sel  = 2'd1;
    #1;
    check("stat_cnt1", 32'(stat_cnt), 32'd3);
    stat_sel = 2'd0;
    #1;
    check("stat_cnt0", 32'(stat_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/NAND/NOR on W-bit operands) among N requesters.
- Round-robin arbitration, valid/ready handshakes on each request port and on the single result port.
- One registered pipeline stage: result, requester ID and error flag appear the cycle after acceptance.
- Sits between multiple datapath clients and the shared logic unit.

Parameters:
- W, 4, operand/result width in bits.
- N, 4, number of requesters (2..8); IDW = $clog2(N).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester request valid.
- req_ready  output  N  per-requester accept; one-hot or zero.
- req_op  input  3*N  op code of requester i in bits [3i+2:3i].
- req_a  input  W*N  operand a of requester i in bits [W*i+W-1:W*i].
- req_b  input  W*N  operand b, same packing as req_a.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_y  output  W  result.
- res_id  output  IDW  index of the requester that produced res_y.
- res_err  output  1  op code was illegal.

Behaviour:
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND (~(a&b)), 4 NOR (~(a|b)). Codes 5..7 are illegal: res_y=0, res_err=1.
- Reset (async assert, sync-released by the system):
  - res_valid=0, res_y=0, res_id=0, res_err=0.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
- can_accept = !res_valid | res_ready. This is combinational; a full register drains and refills in the same cycle, giving full throughput.
- Grant (combinational, only when can_accept):
  - Scan i = last+1, last+2, ... modulo N. The first i with req_valid[i]=1 wins.
  - req_ready[i]=1 for the winner only. req_ready is all-zero when no request or !can_accept.
- On a handshake (req_valid[g] & req_ready[g]) at edge t:
  - res_y, res_id=g and res_err are loaded; res_valid=1 at t+1. Latency is 1 cycle.
  - last := g.
- No handshake but res_valid & res_ready: res_valid := 0. res_y, res_id and res_err hold their last values.
- Result stall: res_valid=1 and res_ready=0.
  - Output registers are stable; all req_ready=0.
  - Requesters must hold valid and payload until accepted.
- The pointer advances only on an accepted handshake, never on an idle or stalled cycle.
- Wrap-around: after a grant to N-1, the scan starts at 0.
- A single active requester is granted every cycle, with no idle bubbles.
- Reset asserted mid-operation: a pending result is discarded and the pointer returns to N-1 immediately.
- req_ready depends on req_valid, res_valid and res_ready only. There is no combinational path from req_op, req_a or req_b to any ready signal.

Optional Feature:
- Macro LOGIC_OP_ARBITER_STATS_EN.
- When defined:
  - Adds a 16-bit saturating grant counter per requester (stops at 16'hFFFF), reset to 0.
  - Adds ports stat_sel (input IDW) and stat_cnt (output 16); stat_cnt = counter[stat_sel], combinational read.
  - A counter increments on each accepted handshake for its requester.
- When undefined: no counters and no stat ports; the rest of the behaviour is identical.

Decomposition:
- Package logic_op_pkg:
  - enum logic_op_e (OP_AND=3'd0, OP_OR, OP_XOR, OP_NAND, OP_NOR).
  - Function is_legal_op.
  - Constant STAT_W=16.
- Sub-module logic_unit: purely combinational, parameter W, inputs a, b, op, outputs y, err. Instantiated once; it computes the winner's operands, selected by the arbiter.

Test Plan:
- Reset then single op: W=4, requester 2 drives op=XOR, a=4'b1100, b=4'b1010, res_ready=1 -> req_ready=4'b0100 same cycle; next cycle res_valid=1, res_y=4'b0110, res_id=2, res_err=0.
- All ops: requester 0 with a=4'hC, b=4'hA, ops 0..4 back-to-back -> res_y C→8, E, 6, 7, 1 on consecutive cycles, no bubbles.
- Round robin: all 4 request continuously, res_ready=1 -> grant order 0,1,2,3,0,1 with res_id following one cycle later. Then drop requester 1 -> order 2,3,0,2.
- Backpressure: res_ready=0 for 3 cycles with a result pending -> res_y, res_id and res_err stable, req_ready=0. On release, the pending result drains and a new grant occurs the same cycle.
- Illegal op: op=6, a=4'hF, b=4'hF -> res_y=0, res_err=1; the pointer still advances.
- Reset mid-stall, plus stats with LOGIC_OP_ARBITER_STATS_EN:
  - Assert reset_n=0 with res_valid=1 -> res_valid=0 without waiting for a clock, and the next grant goes to requester 0.
  - Stats: 3 grants to requester 1 -> stat_sel=1 gives stat_cnt=3.
